// File: rtl/bp_cce_pkg.sv
// Shared CCE microcode types: instruction word layout, opcodes and fetch FSM states.
`ifndef BP_CCE_INST_ADDR_WIDTH
`define BP_CCE_INST_ADDR_WIDTH 8
`endif

package bp_cce_pkg;

  localparam int bp_cce_inst_target_w = `BP_CCE_INST_ADDR_WIDTH;

  typedef enum logic [3:0] {
    e_op_nop    = 4'h0,
    e_op_branch = 4'h1,
    e_op_alu    = 4'h2,
    e_op_mov    = 4'h3
  } bp_cce_inst_op_e;

  typedef struct packed {
    bp_cce_inst_op_e                 op;
    logic                            predict_taken;
    logic [bp_cce_inst_target_w-1:0] target;
    logic [18:0]                     payload;
  } bp_cce_inst_s;

  localparam int bp_cce_inst_width = $bits(bp_cce_inst_s);

  typedef enum logic [1:0] {
    e_fetch_init  = 2'd0,
    e_fetch_start = 2'd1,
    e_fetch_fetch = 2'd2
  } bp_cce_fetch_state_e;

  function automatic logic is_predicted_taken(input bp_cce_inst_s inst);
    return (inst.op == e_op_branch) && inst.predict_taken;
  endfunction

endpackage

// File: rtl/bp_cce_inst_predecode.sv
// Predicts the next fetch PC from the instruction currently leaving the RAM.
module bp_cce_inst_predecode
  import bp_cce_pkg::*;
#(
  parameter int inst_ram_addr_w = 8
) (
  input  logic [inst_ram_addr_w-1:0]   fetch_pc_i,
  input  logic [bp_cce_inst_width-1:0] inst_i,
  output logic [inst_ram_addr_w-1:0]   predicted_fetch_pc_o
);

  bp_cce_inst_s                 w_inst;
  logic [inst_ram_addr_w-1:0]   w_pc_plus1;
  logic [inst_ram_addr_w-1:0]   w_target;
  logic                         w_unused_bits;

  assign w_inst = bp_cce_inst_s'(inst_i);

  // Both candidates are naturally truncated to the RAM address width (wrap at els-1).
  assign w_pc_plus1 = fetch_pc_i + inst_ram_addr_w'(1);
  assign w_target   = w_inst.target[inst_ram_addr_w-1:0];

  assign predicted_fetch_pc_o = is_predicted_taken(w_inst) ? w_target : w_pc_plus1;

  assign w_unused_bits = ^{w_inst.target, w_inst.payload};

endmodule

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous RAM: one access per cycle, registered read data.
module bsg_mem_1rw_sync #(
  parameter int width_p = 32,
  parameter int els_p = 256,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] r_mem [els_p];
  logic [width_p-1:0] r_data;

  // Writes leave the read register untouched so a stalled consumer keeps its word.
  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      r_mem[addr_i] <= data_i;
    end
    if (v_i & ~w_i) begin
      r_data <= r_mem[addr_i];
    end
  end

  assign data_o = r_data;

endmodule

// File: rtl/bp_cce_inst_fetch.sv
// CCE microcode fetch stage: owns the instruction RAM and fetch PC, steers next PC,
// and loads microcode over the config bus while the engine is held in INIT.
module bp_cce_inst_fetch
  import bp_cce_pkg::*;
#(
  parameter int inst_ram_els_p = 256,
  localparam int inst_ram_addr_w = $clog2(inst_ram_els_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         cfg_normal_mode_i,
  input  logic                         cfg_w_v_i,
  input  logic                         cfg_r_v_i,
  input  logic [inst_ram_addr_w-1:0]   cfg_addr_i,
  input  logic [bp_cce_inst_width-1:0] cfg_data_i,
  output logic                         cfg_ready_o,
  output logic [bp_cce_inst_width-1:0] cfg_data_o,
  output logic                         cfg_data_v_o,
  output logic [bp_cce_inst_width-1:0] inst_o,
  output logic                         inst_v_o,
  input  logic                         inst_yumi_i,
  output logic [inst_ram_addr_w-1:0]   fetch_pc_o,
  input  logic                         mispredict_i,
  input  logic [inst_ram_addr_w-1:0]   mispredict_pc_i
);

  bp_cce_fetch_state_e          r_state;
  bp_cce_fetch_state_e          w_state_n;
  logic [inst_ram_addr_w-1:0]   r_fetch_pc;
  logic [inst_ram_addr_w-1:0]   w_fetch_pc_n;
  logic                         r_cfg_data_v;
  logic [bp_cce_inst_width-1:0] w_ram_dout;
  logic [inst_ram_addr_w-1:0]   w_predicted_pc;
  logic [inst_ram_addr_w-1:0]   w_next_pc;
  logic                         w_cfg_ready;
  logic                         w_inst_v;
  logic                         w_ram_v;
  logic                         w_ram_w;
  logic [inst_ram_addr_w-1:0]   w_ram_addr;

  bp_cce_inst_predecode #(
    .inst_ram_addr_w(inst_ram_addr_w)
  ) u_predecode (
    .fetch_pc_i          (r_fetch_pc),
    .inst_i              (w_ram_dout),
    .predicted_fetch_pc_o(w_predicted_pc)
  );

  // Flat priority mux on the critical loop: mispredict, then stall, then prediction.
  assign w_next_pc = mispredict_i  ? mispredict_pc_i :
                     ~inst_yumi_i  ? r_fetch_pc      :
                                     w_predicted_pc;

  bsg_mem_1rw_sync #(
    .width_p(bp_cce_inst_width),
    .els_p  (inst_ram_els_p)
  ) u_inst_ram (
    .clk_i (clk_i),
    .v_i   (w_ram_v),
    .w_i   (w_ram_w),
    .addr_i(w_ram_addr),
    .data_i(cfg_data_i),
    .data_o(w_ram_dout)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= e_fetch_init;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (!cfg_normal_mode_i) begin
      w_state_n = e_fetch_init;
    end else begin
      case (r_state)
        e_fetch_init:  w_state_n = e_fetch_start;
        e_fetch_start: w_state_n = e_fetch_fetch;
        e_fetch_fetch: w_state_n = e_fetch_fetch;
        default:       w_state_n = e_fetch_init;
      endcase
    end
  end

  always_comb begin
    w_cfg_ready  = 1'b0;
    w_inst_v     = 1'b0;
    w_ram_v      = 1'b0;
    w_ram_w      = 1'b0;
    w_ram_addr   = '0;
    w_fetch_pc_n = '0;
    case (r_state)
      e_fetch_init: begin
        // Held low while reset is asserted so no config access is accepted then.
        w_cfg_ready = reset_n_i;
        w_ram_v     = w_cfg_ready & (cfg_w_v_i | cfg_r_v_i);
        w_ram_w     = w_cfg_ready & cfg_w_v_i;
        w_ram_addr  = cfg_addr_i;
      end
      e_fetch_start: begin
        w_ram_v = 1'b1;
      end
      e_fetch_fetch: begin
        w_inst_v     = ~mispredict_i;
        w_ram_v      = 1'b1;
        w_ram_addr   = w_next_pc;
        w_fetch_pc_n = cfg_normal_mode_i ? w_next_pc : '0;
      end
      default: begin
        w_cfg_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_fetch_pc <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_n;
    end
  end

  // A readback accepted on the cycle normal mode is requested is dropped.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cfg_data_v <= 1'b0;
    end else begin
      r_cfg_data_v <= w_cfg_ready & cfg_r_v_i & ~cfg_w_v_i & ~cfg_normal_mode_i;
    end
  end

  assign cfg_ready_o  = w_cfg_ready;
  assign cfg_data_o   = w_ram_dout;
  assign cfg_data_v_o = r_cfg_data_v;
  assign inst_o       = w_ram_dout;
  assign inst_v_o     = w_inst_v;
  assign fetch_pc_o   = r_fetch_pc;

endmodule

// File: tb/tb_bp_cce_inst_fetch.sv
// Bench for the CCE fetch stage: directed scenarios plus a randomized run against a PC-level model.
module tb_bp_cce_inst_fetch;
  import bp_cce_pkg::*;

  localparam int W = $bits(bp_cce_inst_s);

  logic         clk = 1'b0;
  logic         reset_n;
  logic         mode, cfg_w, cfg_r, yumi, mp;
  logic [7:0]   cfg_addr, mpc;
  logic [W-1:0] cfg_data;
  logic         cfg_ready, cfg_data_v, inst_v;
  logic [W-1:0] cfg_dout, inst;
  logic [7:0]   fpc;
  logic         s_cfg_ready, s_cfg_data_v, s_inst_v;
  logic [W-1:0] s_cfg_dout, s_inst;
  logic [1:0]   s_fpc;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] model_mem [0:255];

  always #5 clk = ~clk;

  bp_cce_inst_fetch #(.inst_ram_els_p(256)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .cfg_normal_mode_i(mode),
    .cfg_w_v_i(cfg_w), .cfg_r_v_i(cfg_r), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .cfg_ready_o(cfg_ready), .cfg_data_o(cfg_dout), .cfg_data_v_o(cfg_data_v),
    .inst_o(inst), .inst_v_o(inst_v), .inst_yumi_i(yumi), .fetch_pc_o(fpc),
    .mispredict_i(mp), .mispredict_pc_i(mpc)
  );

  bp_cce_inst_fetch #(.inst_ram_els_p(4)) dut_small (
    .clk_i(clk), .reset_n_i(reset_n), .cfg_normal_mode_i(mode),
    .cfg_w_v_i(cfg_w), .cfg_r_v_i(cfg_r), .cfg_addr_i(cfg_addr[1:0]), .cfg_data_i(cfg_data),
    .cfg_ready_o(s_cfg_ready), .cfg_data_o(s_cfg_dout), .cfg_data_v_o(s_cfg_data_v),
    .inst_o(s_inst), .inst_v_o(s_inst_v), .inst_yumi_i(yumi), .fetch_pc_o(s_fpc),
    .mispredict_i(mp), .mispredict_pc_i(mpc[1:0])
  );

  function automatic logic [W-1:0] mk_nop(input int pl);
    bp_cce_inst_s s;
    s = '0;
    s.op = e_op_nop;
    s.payload = 19'(pl);
    return s;
  endfunction

  function automatic logic [W-1:0] mk_br(input bit taken, input int tgt);
    bp_cce_inst_s s;
    s = '0;
    s.op = e_op_branch;
    s.predict_taken = taken;
    s.target = 8'(tgt);
    s.payload = 19'($urandom);
    return s;
  endfunction

  // Architectural next PC: predicted-taken branch jumps to target, otherwise PC+1, modulo depth.
  function automatic int ref_next(input int pc, input logic [W-1:0] w, input int els);
    bp_cce_inst_s s;
    s = w;
    if (s.op == e_op_branch && s.predict_taken) return int'(s.target) % els;
    return (pc + 1) % els;
  endfunction

  task automatic cfg_write(input int a, input logic [W-1:0] d);
    cfg_w = 1'b1; cfg_addr = 8'(a); cfg_data = d;
    model_mem[8'(a)] = d;
    @(negedge clk);
    cfg_w = 1'b0;
  endtask

  task automatic go_init();
    mode = 1'b0; yumi = 1'b0; mp = 1'b0; cfg_w = 1'b0; cfg_r = 1'b0;
    @(negedge clk);
  endtask

  task automatic enter_normal();
    mode = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mode = 1'b0; cfg_w = 1'b0; cfg_r = 1'b0; yumi = 1'b0; mp = 1'b0;
    cfg_addr = '0; cfg_data = '0; mpc = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (inst_v !== 1'b0 || cfg_ready !== 1'b0 || cfg_data_v !== 1'b0 || fpc !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b rdy=%b dv=%b pc=%0d, expected 0 0 0 0", inst_v, cfg_ready, cfg_data_v, fpc);
    end
    n_checks++;
    if (s_inst_v !== 1'b0 || s_cfg_ready !== 1'b0 || s_cfg_data_v !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_small: got v=%b rdy=%b dv=%b, expected 0 0 0", s_inst_v, s_cfg_ready, s_cfg_data_v);
    end
    reset_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || inst_v !== 1'b0) begin
      n_fail++;
      $display("FAIL init_after_reset: got rdy=%b v=%b, expected rdy=1 v=0", cfg_ready, inst_v);
    end
  endtask

  task automatic test_program();
    int exp_pc[6] = '{0, 1, 2, 0, 1, 2};
    go_init();
    cfg_write(0, mk_nop(1));
    cfg_write(1, mk_nop(2));
    cfg_write(2, mk_br(1'b1, 0));
    enter_normal();
    for (int i = 0; i < 6; i++) begin
      yumi = 1'b1; mp = 1'b0; #1;
      n_checks++;
      if (inst_v !== 1'b1 || fpc !== 8'(exp_pc[i]) || inst !== model_mem[8'(exp_pc[i])]) begin
        n_fail++;
        $display("FAIL program_seq[%0d]: got v=%b pc=%0d inst=%h, expected v=1 pc=%0d inst=%h",
                 i, inst_v, fpc, inst, exp_pc[i], model_mem[8'(exp_pc[i])]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    int   exp_pc[7] = '{0, 1, 1, 1, 1, 2, 0};
    bit   y[7]      = '{1, 0, 0, 0, 1, 1, 1};
    go_init();
    enter_normal();
    for (int i = 0; i < 7; i++) begin
      yumi = y[i]; mp = 1'b0; #1;
      n_checks++;
      if (inst_v !== 1'b1 || fpc !== 8'(exp_pc[i]) || inst !== model_mem[8'(exp_pc[i])]) begin
        n_fail++;
        $display("FAIL stall_seq[%0d]: got v=%b pc=%0d inst=%h, expected v=1 pc=%0d inst=%h",
                 i, inst_v, fpc, inst, exp_pc[i], model_mem[8'(exp_pc[i])]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mispredict();
    go_init();
    cfg_write(3, mk_nop(33));
    enter_normal();
    yumi = 1'b1; @(negedge clk);
    @(negedge clk);
    mp = 1'b1; mpc = 8'd3; #1;
    n_checks++;
    if (inst_v !== 1'b0) begin
      n_fail++;
      $display("FAIL mispredict_squash: got v=%b, expected v=0", inst_v);
    end
    @(negedge clk);
    mp = 1'b0; #1;
    n_checks++;
    if (inst_v !== 1'b1 || fpc !== 8'd3 || inst !== model_mem[3]) begin
      n_fail++;
      $display("FAIL mispredict_redirect: got v=%b pc=%0d inst=%h, expected v=1 pc=3 inst=%h", inst_v, fpc, inst, model_mem[3]);
    end
    mp = 1'b1; mpc = 8'd1; yumi = 1'b0; #1;
    n_checks++;
    if (inst_v !== 1'b0) begin
      n_fail++;
      $display("FAIL mispredict_with_stall: got v=%b, expected v=0", inst_v);
    end
    @(negedge clk);
    mp = 1'b0; yumi = 1'b1; #1;
    n_checks++;
    if (inst_v !== 1'b1 || fpc !== 8'd1 || inst !== model_mem[1]) begin
      n_fail++;
      $display("FAIL mispredict_beats_stall: got v=%b pc=%0d, expected v=1 pc=1", inst_v, fpc);
    end
    @(negedge clk);
  endtask

  task automatic test_mode_drop();
    go_init();
    enter_normal();
    yumi = 1'b1; @(negedge clk);
    @(negedge clk);
    mode = 1'b0; #1;
    n_checks++;
    if (inst_v !== 1'b1 || fpc !== 8'd2) begin
      n_fail++;
      $display("FAIL drop_same_cycle: got v=%b pc=%0d, expected v=1 pc=2", inst_v, fpc);
    end
    @(negedge clk); #1;
    n_checks++;
    if (inst_v !== 1'b0 || fpc !== 8'd0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_next_cycle: got v=%b pc=%0d rdy=%b, expected v=0 pc=0 rdy=1", inst_v, fpc, cfg_ready);
    end
    mode = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (inst_v !== 1'b0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reenter_start: got v=%b rdy=%b, expected v=0 rdy=0", inst_v, cfg_ready);
    end
    @(negedge clk); #1;
    n_checks++;
    if (inst_v !== 1'b1 || fpc !== 8'd0 || inst !== model_mem[0]) begin
      n_fail++;
      $display("FAIL reenter_fetch: got v=%b pc=%0d inst=%h, expected v=1 pc=0 inst=%h", inst_v, fpc, inst, model_mem[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_cfg_ignore();
    logic [W-1:0] old_word;
    old_word = 32'hA5A5_0123;
    go_init();
    cfg_write(7, old_word);
    enter_normal();
    yumi = 1'b1; cfg_w = 1'b1; cfg_addr = 8'd7; cfg_data = 32'h5; #1;
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_ready_in_fetch: got %b, expected 0", cfg_ready);
    end
    @(negedge clk);
    cfg_w = 1'b0;
    go_init();
    cfg_r = 1'b1; cfg_addr = 8'd7; #1;
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_ready_in_init: got %b, expected 1", cfg_ready);
    end
    @(negedge clk);
    cfg_r = 1'b0; #1;
    n_checks++;
    if (cfg_data_v !== 1'b1 || cfg_dout !== old_word || s_cfg_dout !== old_word) begin
      n_fail++;
      $display("FAIL cfg_readback: got dv=%b data=%h small=%h, expected dv=1 data=%h", cfg_data_v, cfg_dout, s_cfg_dout, old_word);
    end
    @(negedge clk); #1;
    n_checks++;
    if (cfg_data_v !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_data_v_pulse: got %b, expected 0", cfg_data_v);
    end
  endtask

  task automatic test_reset_mid();
    go_init();
    enter_normal();
    yumi = 1'b1; @(negedge clk);
    reset_n = 1'b0; #1;
    n_checks++;
    if (inst_v !== 1'b0 || fpc !== 8'd0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b pc=%0d rdy=%b, expected 0 0 0", inst_v, fpc, cfg_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (inst_v !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_start: got v=%b, expected 0", inst_v);
    end
    @(negedge clk); #1;
    n_checks++;
    if (inst_v !== 1'b1 || fpc !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got v=%b pc=%0d, expected v=1 pc=0", inst_v, fpc);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    go_init();
    for (int a = 0; a < 4; a++) cfg_write(a, mk_nop(100 + a));
    enter_normal();
    for (int i = 0; i < 6; i++) begin
      yumi = 1'b1; #1;
      n_checks++;
      if (s_inst_v !== 1'b1 || s_fpc !== 2'(i % 4) || s_inst !== model_mem[8'(i % 4)]) begin
        n_fail++;
        $display("FAIL wrap_seq[%0d]: got v=%b pc=%0d inst=%h, expected v=1 pc=%0d inst=%h",
                 i, s_inst_v, s_fpc, s_inst, i % 4, model_mem[8'(i % 4)]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int pc;
    bit y, m;
    int mt;
    go_init();
    for (int a = 0; a < 32; a++) begin
      if (a == 31) cfg_write(a, mk_br(1'b1, $urandom_range(0, 31)));
      else if ($urandom_range(0, 9) < 6) cfg_write(a, mk_nop($urandom_range(0, 1000)));
      else cfg_write(a, mk_br(1'($urandom_range(0, 1)), $urandom_range(0, 31)));
    end
    enter_normal();
    pc = 0;
    for (int i = 0; i < 300; i++) begin
      y = ($urandom_range(0, 9) < 7);
      m = ($urandom_range(0, 9) == 0);
      mt = $urandom_range(0, 31);
      yumi = y; mp = m; mpc = 8'(mt); #1;
      n_checks++;
      if (m) begin
        if (inst_v !== 1'b0) begin
          n_fail++;
          $display("FAIL random_squash[%0d]: got v=%b, expected v=0", i, inst_v);
        end
      end else if (inst_v !== 1'b1 || fpc !== 8'(pc) || inst !== model_mem[8'(pc)]) begin
        n_fail++;
        $display("FAIL random_fetch[%0d]: got v=%b pc=%0d inst=%h, expected v=1 pc=%0d inst=%h",
                 i, inst_v, fpc, inst, pc, model_mem[8'(pc)]);
      end
      if (m) pc = mt;
      else if (y) pc = ref_next(pc, model_mem[8'(pc)], 256);
      @(negedge clk);
    end
    mp = 1'b0; yumi = 1'b0;
  endtask

  initial begin
    test_reset();
    test_program();
    test_stall();
    test_mispredict();
    test_mode_drop();
    test_cfg_ignore();
    test_reset_mid();
    test_wrap();
    test_random();
    go_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
